fan_seg_scan: RTL and testbench
===============================

Name: fan_seg_scan

Overview:
- Parametrised, pipelined successor to the fixed 32-lane forwarding adder network in the sparse tensor core datapath.
- Accepts one vector of NUM_IN lines per cycle; each line is {data, row, ctrl}.
- Computes a segmented inclusive prefix sum over maximal runs of adjacent valid lanes that share the same row ID, and flags the lane holding each run's total.
- Sits between the sparse multiplier array and the row accumulator, with valid/ready backpressure on both sides.

Parameters:
- NUM_IN, 32, lane count; power of two, 2..64.
- LOG_IN, $clog2(NUM_IN), number of scan stages (derived; do not override).
- DW_DATA, 32, data width, two's complement.
- DW_ROW, 5, row ID width.
- DW_CTRL, 4, control width; minimum 2.
- DW_LINE, DW_DATA+DW_ROW+DW_CTRL, line width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector this cycle.
- in  in  NUM_IN*DW_LINE  lane i occupies [i*DW_LINE +: DW_LINE]; line = {data[MSBs], row, ctrl[LSBs]}.
- out_valid  out  1  output vector valid.
- out_ready  in  1  downstream accepts the output vector.
- out  out  NUM_IN*DW_LINE  result lines, same packing as in.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Input ctrl fields:
  - ctrl[0] = lane valid.
  - ctrl[DW_CTRL-1:2] are sideband bits, carried unchanged to the same output lane.
  - Input ctrl[1] is ignored.
- Run definition:
  - Lane i continues the run of lane i-1 iff both lanes are valid and row[i]==row[i-1].
  - Lane 0 always starts a run.
  - An invalid lane belongs to no run.
- Output lane i, valid lane:
  - data = sum of in data from its run start through lane i, inclusive.
  - row = in row[i].
  - ctrl[0] = 1.
  - ctrl[1] = 1 iff lane i is the last lane of its run (i==NUM_IN-1, or lane i+1 is not in the run).
- Output lane i, invalid lane: data=0, row=0, ctrl[1:0]=0, sideband bits still passed through.
- Arithmetic: sums wrap modulo 2^DW_DATA; no carry-out (see optional feature).
- Structure:
  - Stage 0 registers decoded lanes and segment-start flags.
  - Stages 1..LOG_IN form a Hillis-Steele segmented scan at stride 2^(k-1). Lane i combines with lane i-stride only if no segment start lies in (i-stride, i].
  - The final stage computes ctrl[1] and drives the output register.
- Latency and throughput:
  - Exactly LOG_IN+1 cycles from input handshake (in_valid&&in_ready) to out_valid, when there is no stall.
  - Throughput is 1 vector/cycle.
- Backpressure:
  - Global enable en = !(out_valid && !out_ready).
  - in_ready = en, combinational from out_valid/out_ready only; it never depends on in_valid.
  - When en=0, every stage register and per-stage valid bit holds.
  - Bubbles are not squeezed.
- Handshake rules: out and out_valid are stable while out_valid && !out_ready. A vector presented with in_valid=1, in_ready=0 is not consumed.
- Reset:
  - All stage registers, valid bits, out and out_valid clear to 0 on the next edge.
  - in_ready=1 after reset.
  - Reset mid-operation discards every in-flight vector; no partial output is produced.
- Boundary cases:
  - All lanes invalid: out_valid still asserts, and all lines are 0 apart from sideband bits.
  - All lanes share one row: lane NUM_IN-1 holds the full sum and ctrl[1] is set only there.
  - Same row ID separated by an invalid lane forms two separate runs.

Optional Feature:
- Macro: FAN_SEG_SAT_EN.
- Defined: every scan addition saturates to the signed range [-2^(DW_DATA-1), 2^(DW_DATA-1)-1]. When ctrl[1]=1, output ctrl[1] is unchanged and a saturation event anywhere in that run sets sideband bit ctrl[2], ORed with the incoming bit. This requires DW_CTRL>=3, checked by an elaboration-time error.
- Undefined: additions wrap and ctrl[2] passes through untouched.
- Latency is identical in both builds.

Test Plan:
- Bench configuration: NUM_IN=8, DW_DATA=8, DW_ROW=3, DW_CTRL=4.
- Lanes all valid, rows {0,0,1,1,1,2,3,3}, data {1,2,3,4,5,6,7,8} -> out data {1,3,3,7,12,6,7,15}, ctrl[1] set on lanes {1,4,5,7}, out_valid exactly 4 cycles after accept.
- Rows all 5, data all 1, lane 3 invalid -> data {1,2,3,0,1,2,3,4}, ctrl[1] on lanes {2,7}, lane 3 line zero.
- Stream 6 back-to-back vectors; hold out_ready=0 for 3 cycles at cycle 5 -> in_ready low during the hold, no vector lost or duplicated, out stable while stalled, order preserved.
- Assert rst for 1 cycle while 3 vectors are in flight -> out_valid=0 next cycle, no stale vector emerges, the next accepted vector appears 4 cycles later.
- Wrap vs saturation: one run of data {100,100} -> lane 1 = 200 mod 256 (-56) without the macro; 127 with ctrl[2]=1 when FAN_SEG_SAT_EN is defined.
- Sideband: ctrl[3]=1 on lanes 0 and 6 only -> same lanes show ctrl[3]=1 at the output regardless of validity.

Source files
------------

// File: rtl/fan_seg_scan.sv
// fan_seg_scan -- pipelined segmented inclusive prefix-sum network.
//
// Takes one vector of NUM_IN lines per cycle. Each line is {data, row, ctrl}.
// For each maximal run of adjacent valid lanes that share a row ID, the block
// produces the running sum of data and flags the lane that holds the run total.
//
// Pipeline: stage 0 decodes the lanes, stages 1..LOG_IN form a Hillis-Steele
// segmented scan, and a final stage registers the output. Latency is LOG_IN+1
// cycles and throughput is one vector per cycle.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   in_valid   input vector valid
//   in_ready   block accepts a vector this cycle
//   in         NUM_IN lines; lane i at [i*DW_LINE +: DW_LINE]
//   out_valid  output vector valid
//   out_ready  downstream accepts the output vector
//   out        result lines, packed the same way as in
//
// Line fields: data in the MSBs, then row, then ctrl in the LSBs.
//   ctrl[0]           lane valid
//   ctrl[1]           input: ignored; output: last lane of its run
//   ctrl[DW_CTRL-1:2] sideband, passed through unchanged
//
// Optional build macro FAN_SEG_SAT_EN: each scan addition saturates to the
// signed data range. A saturation anywhere in a run sets ctrl[2] on the lane
// that holds the run total. This build needs DW_CTRL >= 3. Without the macro,
// additions wrap and ctrl[2] is passed through untouched.
module fan_seg_scan #(
  parameter  int NUM_IN  = 32,
  parameter  int DW_DATA = 32,
  parameter  int DW_ROW  = 5,
  parameter  int DW_CTRL = 4,
  localparam int LOG_IN  = $clog2(NUM_IN),
  localparam int DW_LINE = DW_DATA + DW_ROW + DW_CTRL
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_IN*DW_LINE-1:0] in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_IN*DW_LINE-1:0] out
);

`ifdef FAN_SEG_SAT_EN
  if (DW_CTRL < 3) begin : g_ctrl_width_check
    $error("fan_seg_scan: FAN_SEG_SAT_EN requires DW_CTRL >= 3");
  end
`endif

  // Scan addition. The saturating build clamps to the signed range.
  function automatic logic [DW_DATA-1:0] add_data(input logic [DW_DATA-1:0] a,
                                                  input logic [DW_DATA-1:0] b);
    logic [DW_DATA-1:0] sum;
    sum = a + b;
`ifdef FAN_SEG_SAT_EN
    if ((a[DW_DATA-1] == b[DW_DATA-1]) && (sum[DW_DATA-1] != a[DW_DATA-1])) begin
      sum = a[DW_DATA-1] ? {1'b1, {(DW_DATA-1){1'b0}}} : {1'b0, {(DW_DATA-1){1'b1}}};
    end
`endif
    return sum;
  endfunction

`ifdef FAN_SEG_SAT_EN
  // Signed overflow of a + b.
  function automatic logic add_ovf(input logic [DW_DATA-1:0] a,
                                   input logic [DW_DATA-1:0] b);
    logic [DW_DATA-1:0] sum;
    sum = a + b;
    return (a[DW_DATA-1] == b[DW_DATA-1]) && (sum[DW_DATA-1] != a[DW_DATA-1]);
  endfunction
`endif

  // Source lane for lane i in scan stage k. Lanes below the stride read
  // themselves; these lanes never combine, so the result is not used.
  function automatic int src_idx(input int i, input int k);
    return (i >= (1 << (k - 1))) ? (i - (1 << (k - 1))) : i;
  endfunction

  logic en;

  logic [DW_DATA-1:0] in_data_s  [0:NUM_IN-1];
  logic [DW_ROW-1:0]  in_row_s   [0:NUM_IN-1];
  logic [DW_CTRL-1:0] in_ctrl_s  [0:NUM_IN-1];
  logic [NUM_IN-1:0]  in_vld_s;
  logic [NUM_IN-1:0]  in_start_s;

  // Per-stage state. flag_r marks a run start inside the window that the lane
  // has already accumulated. end_r marks that the next lane starts a new run.
  logic [LOG_IN:0]    stage_vld_r;
  logic [NUM_IN-1:0]  lane_vld_r [0:LOG_IN];
  logic [NUM_IN-1:0]  end_r      [0:LOG_IN];
  logic [NUM_IN-1:0]  flag_r     [0:LOG_IN];
  logic [DW_DATA-1:0] data_r     [0:LOG_IN][0:NUM_IN-1];
  logic [DW_ROW-1:0]  row_r      [0:LOG_IN][0:NUM_IN-1];
  logic [DW_CTRL-1:0] ctrl_r     [0:LOG_IN][0:NUM_IN-1];

  logic [DW_DATA-1:0] sum_s      [1:LOG_IN][0:NUM_IN-1];
  logic [NUM_IN-1:0]  flag_s     [1:LOG_IN];

`ifdef FAN_SEG_SAT_EN
  logic [NUM_IN-1:0]  sat_r      [0:LOG_IN];
  logic [NUM_IN-1:0]  sat_s      [1:LOG_IN];
`endif

  logic [DW_CTRL-1:0]        ctrl_out_s [0:NUM_IN-1];
  logic [NUM_IN*DW_LINE-1:0] out_next_s;

  // The whole pipeline moves only when the output slot is free or being taken.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  // Unpack the input lanes and find the run starts.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      in_data_s[i] = in[i*DW_LINE + DW_CTRL + DW_ROW +: DW_DATA];
      in_row_s[i]  = in[i*DW_LINE + DW_CTRL +: DW_ROW];
      in_ctrl_s[i] = in[i*DW_LINE +: DW_CTRL];
      in_vld_s[i]  = in_ctrl_s[i][0];
    end
    in_start_s    = '0;
    in_start_s[0] = 1'b1;
    // An invalid lane counts as a start. It keeps neighbours apart, and because
    // its data is zeroed it never contributes to a sum.
    for (int i = 1; i < NUM_IN; i++) begin
      in_start_s[i] = !in_vld_s[i] || !in_vld_s[i-1] || (in_row_s[i] != in_row_s[i-1]);
    end
  end

  // One scan step per stage. A lane combines with lane i-stride only if no run
  // start lies in (i-stride, i].
  always_comb begin
    for (int k = 1; k <= LOG_IN; k++) begin
      flag_s[k] = flag_r[k-1];
`ifdef FAN_SEG_SAT_EN
      sat_s[k]  = sat_r[k-1];
`endif
      for (int i = 0; i < NUM_IN; i++) begin
        sum_s[k][i] = data_r[k-1][i];
        if ((i >= (1 << (k - 1))) && !flag_r[k-1][i]) begin
          sum_s[k][i]  = add_data(data_r[k-1][src_idx(i, k)], data_r[k-1][i]);
          flag_s[k][i] = flag_r[k-1][src_idx(i, k)];
`ifdef FAN_SEG_SAT_EN
          sat_s[k][i]  = sat_r[k-1][i] | sat_r[k-1][src_idx(i, k)] |
                         add_ovf(data_r[k-1][src_idx(i, k)], data_r[k-1][i]);
`endif
        end else begin
          sum_s[k][i] = data_r[k-1][i];
        end
      end
    end
  end

  // Final stage: rebuild the ctrl field and pack the output lines.
  always_comb begin
    out_next_s = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      ctrl_out_s[i]    = ctrl_r[LOG_IN][i];
      ctrl_out_s[i][0] = lane_vld_r[LOG_IN][i];
      ctrl_out_s[i][1] = lane_vld_r[LOG_IN][i] & end_r[LOG_IN][i];
`ifdef FAN_SEG_SAT_EN
      ctrl_out_s[i][2] = ctrl_r[LOG_IN][i][2] |
                         (lane_vld_r[LOG_IN][i] & end_r[LOG_IN][i] & sat_r[LOG_IN][i]);
`endif
      out_next_s[i*DW_LINE +: DW_LINE] = {data_r[LOG_IN][i], row_r[LOG_IN][i], ctrl_out_s[i]};
    end
  end

  // Pipeline registers: decode stage, scan stages and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_vld_r <= '0;
      out_valid   <= 1'b0;
      out         <= '0;
      for (int k = 0; k <= LOG_IN; k++) begin
        lane_vld_r[k] <= '0;
        end_r[k]      <= '0;
        flag_r[k]     <= '0;
`ifdef FAN_SEG_SAT_EN
        sat_r[k]      <= '0;
`endif
        for (int i = 0; i < NUM_IN; i++) begin
          data_r[k][i] <= '0;
          row_r[k][i]  <= '0;
          ctrl_r[k][i] <= '0;
        end
      end
    end else if (en) begin
      stage_vld_r   <= {stage_vld_r[LOG_IN-1:0], in_valid};
      out_valid     <= stage_vld_r[LOG_IN];
      out           <= out_next_s;
      lane_vld_r[0] <= in_vld_s;
      end_r[0]      <= {1'b1, in_start_s[NUM_IN-1:1]};
      flag_r[0]     <= in_start_s;
`ifdef FAN_SEG_SAT_EN
      sat_r[0]      <= '0;
`endif
      for (int i = 0; i < NUM_IN; i++) begin
        data_r[0][i] <= in_vld_s[i] ? in_data_s[i] : '0;
        row_r[0][i]  <= in_vld_s[i] ? in_row_s[i] : '0;
        ctrl_r[0][i] <= in_ctrl_s[i];
      end
      for (int k = 1; k <= LOG_IN; k++) begin
        lane_vld_r[k] <= lane_vld_r[k-1];
        end_r[k]      <= end_r[k-1];
        flag_r[k]     <= flag_s[k];
`ifdef FAN_SEG_SAT_EN
        sat_r[k]      <= sat_s[k];
`endif
        for (int i = 0; i < NUM_IN; i++) begin
          data_r[k][i] <= sum_s[k][i];
          row_r[k][i]  <= row_r[k-1][i];
          ctrl_r[k][i] <= ctrl_r[k-1][i];
        end
      end
    end
  end

endmodule

// File: tb/tb_fan_seg_scan.sv
// Directed testbench for fan_seg_scan (NUM_IN=8, DW_DATA=8, DW_ROW=3, DW_CTRL=4).
// It applies a table of vectors one at a time and checks each result and its
// latency. It then checks a stalled back-to-back stream and a mid-flight reset.
module tb_fan_seg_scan;

  localparam int N  = 8;
  localparam int LW = 15;
  localparam int VW = N * LW;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_bus;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_bus;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [VW-1:0] vin;
    logic [VW-1:0] vexp;
  } vec_t;

  vec_t tbl [0:6];

  fan_seg_scan #(
    .NUM_IN (8),
    .DW_DATA(8),
    .DW_ROW (3),
    .DW_CTRL(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in       (in_bus),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  // Build one line: {data, row, ctrl}.
  function automatic logic [LW-1:0] ln(input int d, input int r, input int c);
    return {d[7:0], r[2:0], c[3:0]};
  endfunction

  task automatic check(input bit ok, input string name, input logic [VW-1:0] act,
                       input logic [VW-1:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one vector and wait for its result. The result must arrive exactly
  // 4 cycles after it is accepted.
  task automatic run_single(input logic [VW-1:0] vin, input logic [VW-1:0] vexp,
                            input string name);
    int lat;
    @(posedge clk); #1;
    in_bus   = vin;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_bus   = '0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check(lat == 4, {name, "_latency"}, VW'(lat), VW'(4));
    check(out_bus === vexp, name, out_bus, vexp);
  endtask

  task automatic drive_stream();
    int n;
    int guard;
    bit rdy;
    n = 0;
    guard = 0;
    in_bus   = tbl[0].vin;
    in_valid = 1'b1;
    while (n < 6 && guard < 60) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      guard++;
      if (rdy) begin
        n++;
        if (n < 6) begin
          in_bus = tbl[n].vin;
        end else begin
          in_valid = 1'b0;
          in_bus   = '0;
        end
      end
    end
    check(n == 6, "stream_accept", VW'(n), VW'(6));
  endtask

  task automatic stall_ctl();
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
  endtask

  task automatic collect_stream();
    int got;
    bit held_v;
    logic [VW-1:0] held;
    got = 0;
    held_v = 1'b0;
    held = '0;
    for (int c = 0; c < 80 && got < 6; c++) begin
      @(negedge clk);
      if (held_v) begin
        check(out_valid && (out_bus === held), "stall_hold", out_bus, held);
        held_v = 1'b0;
      end
      if (out_valid && !out_ready) begin
        check(in_ready == 1'b0, "stall_in_ready", VW'(in_ready), VW'(0));
        held   = out_bus;
        held_v = 1'b1;
      end else if (out_valid && out_ready) begin
        check(out_bus === tbl[got].vexp, $sformatf("stream_out%0d", got), out_bus,
              tbl[got].vexp);
        got++;
      end
    end
    check(got == 6, "stream_count", VW'(got), VW'(6));
  endtask

  initial begin
    bit stale;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bus    = '0;
    out_ready = 1'b1;

    // Lanes are listed from lane 7 down to lane 0.
    tbl[0].vin  = {ln(8,3,1), ln(7,3,1), ln(6,2,1), ln(5,1,1), ln(4,1,1), ln(3,1,1), ln(2,0,1), ln(1,0,1)};
    tbl[0].vexp = {ln(15,3,3), ln(7,3,1), ln(6,2,3), ln(12,1,3), ln(7,1,1), ln(3,1,1), ln(3,0,3), ln(1,0,1)};
    tbl[1].vin  = {ln(1,5,1), ln(1,5,1), ln(1,5,1), ln(1,5,1), ln(1,5,0), ln(1,5,1), ln(1,5,1), ln(1,5,1)};
    tbl[1].vexp = {ln(4,5,3), ln(3,5,1), ln(2,5,1), ln(1,5,1), ln(0,0,0), ln(3,5,3), ln(2,5,1), ln(1,5,1)};
    tbl[2].vin  = {ln(9,4,0), ln(9,4,0), ln(9,4,0), ln(9,4,0), ln(9,4,0), ln(9,4,0), ln(100,0,1), ln(100,0,1)};
`ifdef FAN_SEG_SAT_EN
    tbl[2].vexp = {ln(0,0,0), ln(0,0,0), ln(0,0,0), ln(0,0,0), ln(0,0,0), ln(0,0,0), ln(127,0,7), ln(100,0,1)};
`else
    tbl[2].vexp = {ln(0,0,0), ln(0,0,0), ln(0,0,0), ln(0,0,0), ln(0,0,0), ln(0,0,0), ln(200,0,3), ln(100,0,1)};
`endif
    tbl[3].vin  = {ln(17,7,1), ln(16,6,10), ln(15,5,1), ln(14,4,1), ln(13,3,1), ln(12,1,1), ln(11,1,3), ln(10,0,9)};
    tbl[3].vexp = {ln(17,7,3), ln(0,0,8), ln(15,5,3), ln(14,4,3), ln(13,3,3), ln(23,1,3), ln(11,1,1), ln(10,0,11)};
    tbl[4].vin  = {ln(22,7,0), ln(19,6,0), ln(16,5,2), ln(13,4,0), ln(10,3,0), ln(7,2,4), ln(4,1,0), ln(1,0,0)};
    tbl[4].vexp = {ln(0,0,0), ln(0,0,0), ln(0,0,0), ln(0,0,0), ln(0,0,0), ln(0,0,4), ln(0,0,0), ln(0,0,0)};
    tbl[5].vin  = {ln(8,3,1), ln(7,3,1), ln(6,3,1), ln(5,3,1), ln(4,3,1), ln(3,3,1), ln(2,3,1), ln(1,3,1)};
    tbl[5].vexp = {ln(36,3,3), ln(28,3,1), ln(21,3,1), ln(15,3,1), ln(10,3,1), ln(6,3,1), ln(3,3,1), ln(1,3,1)};
    tbl[6].vin  = {ln(4,0,1), ln(0,0,1), ln(-20,7,1), ln(10,7,1), ln(3,2,1), ln(5,2,1), ln(-2,2,1), ln(-1,2,1)};
    tbl[6].vexp = {ln(4,0,3), ln(0,0,1), ln(-10,7,3), ln(10,7,1), ln(5,2,3), ln(2,2,1), ln(-3,2,1), ln(-1,2,1)};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check(out_valid == 1'b0, "reset_out_valid", VW'(out_valid), VW'(0));
    check(in_ready == 1'b1, "reset_in_ready", VW'(in_ready), VW'(1));
    check(out_bus === '0, "reset_out", out_bus, '0);

    for (int t = 0; t < 7; t++) begin
      run_single(tbl[t].vin, tbl[t].vexp, $sformatf("vec%0d", t));
    end

    // Back-to-back stream with a 3-cycle output stall.
    @(posedge clk); #1;
    fork
      drive_stream();
      stall_ctl();
      collect_stream();
    join
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check(out_valid == 1'b0, "stream_no_dup", VW'(out_valid), VW'(0));
    end

    // Reset while three vectors are in flight.
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      in_bus = tbl[n].vin;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_bus   = '0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check(out_valid == 1'b0, "rst_flight_out_valid", VW'(out_valid), VW'(0));
    stale = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    check(stale == 1'b0, "rst_flight_no_stale", VW'(stale), VW'(0));
    run_single(tbl[1].vin, tbl[1].vexp, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
